// File: rtl/prelude_pkg.sv
// rtl/prelude_pkg.sv - shared FSM states, opcode class and branch condition codes
package prelude_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      EXEC  = 2'd3
   } state_e;

   localparam logic [1:0] OPC_COND = 2'b11;

   typedef enum logic [2:0] {
      COND_NEVER  = 3'd0,
      COND_EQ     = 3'd1,
      COND_LT     = 3'd2,
      COND_LE     = 3'd3,
      COND_ALWAYS = 3'd4,
      COND_NE     = 3'd5,
      COND_GE     = 3'd6,
      COND_GT     = 3'd7
   } cond_e;

   function automatic logic is_cond_op(input logic [7:0] op);
      return op[7:6] == OPC_COND;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - signed condition test of R3 against a 3-bit condition code
module branch_cond_eval
   import prelude_pkg::*;
(
   input  logic [7:0] r3,
   input  logic [2:0] cond,
   output logic       take
);

   logic is_zero;
   logic is_neg;

   assign is_zero = (r3 == 8'h00);
   assign is_neg  = r3[7];

   // Map condition code to outcome; r3 is treated as two's complement
   always_comb begin
      take = 1'b0;
      case (cond)
         COND_NEVER:  take = 1'b0;
         COND_EQ:     take = is_zero;
         COND_LT:     take = is_neg;
         COND_LE:     take = is_neg | is_zero;
         COND_ALWAYS: take = 1'b1;
         COND_NE:     take = ~is_zero;
         COND_GE:     take = ~is_neg;
         COND_GT:     take = ~is_neg & ~is_zero;
         default:     take = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and fetch sequencer with conditional branch redirect
module pc_sequencer
   import prelude_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   output logic            fetch_req,
   output logic [PC_W-1:0] fetch_addr,
   input  logic            fetch_ack,
   input  logic            instr_valid,
   input  logic [7:0]      instr,
   input  logic [7:0]      r3,
   input  logic [PC_W-1:0] jump_target,
   output logic [PC_W-1:0] pc,
   output logic            exec_valid,
   output logic [7:0]      exec_instr,
   output logic            branch_taken
);

   state_e          state;
   logic            cond_take;
   logic            take;
   logic [PC_W-1:0] pc_next;

   branch_cond_eval u_cond (
      .r3   (r3),
      .cond (exec_instr[2:0]),
      .take (cond_take)
   );

   assign take         = is_cond_op(exec_instr) & cond_take;
   assign exec_valid   = (state == EXEC) & ~stall;
   assign branch_taken = exec_valid & take;
   assign pc_next      = take ? jump_target : pc + PC_W'(1);
   assign fetch_addr   = pc;

   // Sequencer: fetch_req is registered so the request rises one cycle after the
   // new pc settles; an ack is only honoured while the request is actually up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         exec_instr <= 8'h00;
         fetch_req  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               fetch_req <= 1'b0;
               state     <= FETCH;
            end
            FETCH: begin
               if (!fetch_req) begin
                  fetch_req <= 1'b1;
               end else if (fetch_ack) begin
                  fetch_req <= 1'b0;
                  if (instr_valid) begin
                     exec_instr <= instr;
                     state      <= EXEC;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (instr_valid) begin
                  exec_instr <= instr;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (!stall) begin
                  pc    <= pc_next;
                  state <= FETCH;
               end
            end
            default: begin
               fetch_req <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stall;
   logic       fetch_req;
   logic [7:0] fetch_addr;
   logic       fetch_ack;
   logic       instr_valid;
   logic [7:0] instr;
   logic [7:0] r3;
   logic [7:0] jump_target;
   logic [7:0] pc;
   logic       exec_valid;
   logic [7:0] exec_instr;
   logic       branch_taken;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] r3_vals [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
   // one row per condition code, MSB = r3 00, LSB = r3 FF
   logic [4:0] cond_tab [8] = '{5'b00000, 5'b10000, 5'b00011, 5'b10011,
                                5'b11111, 5'b01111, 5'b11100, 5'b01100};

   pc_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ack    (fetch_ack),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .r3           (r3),
      .jump_target  (jump_target),
      .pc           (pc),
      .exec_valid   (exec_valid),
      .exec_instr   (exec_instr),
      .branch_taken (branch_taken)
   );

   always #5 clk = ~clk;

   task tick;
      @(posedge clk);
      #1;
   endtask

   task settle;
      #1;
   endtask

   task do_reset;
      rst_n = 1'b0; stall = 1'b0; fetch_ack = 1'b0; instr_valid = 1'b0;
      instr = 8'h00; r3 = 8'h00; jump_target = 8'h00;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task wait_req;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!seen && fetch_req === 1'b1) seen = 1'b1;
         if (!seen) tick;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL wait_req: fetch_req never rose within 10 cycles");
      end
   endtask

   // leaves the bench in the EXEC cycle of the fetched byte
   task run_instr(input logic [7:0] ins);
      wait_req;
      fetch_ack = 1'b1; instr_valid = 1'b1; instr = ins;
      tick;
      fetch_ack = 1'b0; instr_valid = 1'b0;
      settle;
   endtask

   task test_reset;
      rst_n = 1'b0; stall = 1'b0; fetch_ack = 1'b1; instr_valid = 1'b1;
      instr = 8'hAA; r3 = 8'h00; jump_target = 8'h00;
      tick;
      tick;
      vectors++;
      if (pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h want 00", pc); end
      vectors++;
      if (fetch_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", fetch_req); end
      vectors++;
      if (exec_valid !== 1'b0 || branch_taken !== 1'b0) begin
         miscompares++; $display("FAIL reset_exec: got %b/%b want 0/0", exec_valid, branch_taken);
      end
      vectors++;
      if (exec_instr !== 8'h00) begin miscompares++; $display("FAIL reset_instr: got %h want 00", exec_instr); end
   endtask

   task test_streaming;
      do_reset;
      fetch_ack = 1'b1; instr_valid = 1'b1; instr = 8'h00;
      for (int j = 0; j < 3 * 258; j++) begin
         tick;
         vectors++;
         if (fetch_req !== (j % 3 == 1)) begin
            miscompares++; $display("FAIL stream_req j=%0d: got %b want %b", j, fetch_req, (j % 3 == 1));
         end
         vectors++;
         if (exec_valid !== (j % 3 == 2)) begin
            miscompares++; $display("FAIL stream_exec j=%0d: got %b want %b", j, exec_valid, (j % 3 == 2));
         end
         if (j % 3 == 2) begin
            vectors++;
            if (pc !== 8'((j / 3) % 256)) begin
               miscompares++; $display("FAIL stream_pc j=%0d: got %h want %h", j, pc, 8'((j / 3) % 256));
            end
         end
      end
      fetch_ack = 1'b0; instr_valid = 1'b0;
   endtask

   task test_wait_states;
      do_reset;
      tick;
      tick;
      vectors++;
      if (fetch_req !== 1'b1 || fetch_addr !== 8'h00) begin
         miscompares++; $display("FAIL wait_req_up: got %b/%h want 1/00", fetch_req, fetch_addr);
      end
      tick;
      vectors++;
      if (fetch_req !== 1'b1 || fetch_addr !== 8'h00) begin
         miscompares++; $display("FAIL wait_req_hold: got %b/%h want 1/00", fetch_req, fetch_addr);
      end
      fetch_ack = 1'b1;
      tick;
      fetch_ack = 1'b0;
      vectors++;
      if (fetch_req !== 1'b0 || exec_valid !== 1'b0) begin
         miscompares++; $display("FAIL wait_req_drop: got %b/%b want 0/0", fetch_req, exec_valid);
      end
      tick;
      vectors++;
      if (exec_valid !== 1'b0) begin miscompares++; $display("FAIL wait_n2: got %b want 0", exec_valid); end
      tick;
      instr_valid = 1'b1; instr = 8'h05;
      settle;
      vectors++;
      if (exec_valid !== 1'b0) begin miscompares++; $display("FAIL wait_n3: got %b want 0", exec_valid); end
      tick;
      instr_valid = 1'b0;
      vectors++;
      if (exec_valid !== 1'b1 || exec_instr !== 8'h05 || branch_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_n4: got %b/%h/%b want 1/05/0", exec_valid, exec_instr, branch_taken);
      end
      tick;
      vectors++;
      if (pc !== 8'h01 || exec_valid !== 1'b0) begin
         miscompares++; $display("FAIL wait_pc: got %h/%b want 01/0", pc, exec_valid);
      end
   endtask

   task test_branch_eq;
      do_reset;
      r3 = 8'h00; jump_target = 8'h40;
      run_instr(8'hC1);
      vectors++;
      if (exec_valid !== 1'b1 || branch_taken !== 1'b1) begin
         miscompares++; $display("FAIL beq_taken: got %b/%b want 1/1", exec_valid, branch_taken);
      end
      tick;
      vectors++;
      if (fetch_addr !== 8'h40 || branch_taken !== 1'b0) begin
         miscompares++; $display("FAIL beq_target: got %h/%b want 40/0", fetch_addr, branch_taken);
      end
      r3 = 8'h01;
      run_instr(8'hC1);
      vectors++;
      if (exec_valid !== 1'b1 || branch_taken !== 1'b0) begin
         miscompares++; $display("FAIL beq_not: got %b/%b want 1/0", exec_valid, branch_taken);
      end
      tick;
      vectors++;
      if (pc !== 8'h41) begin miscompares++; $display("FAIL beq_inc: got %h want 41", pc); end
   endtask

   task test_cond_table;
      logic [7:0] exp_pc;
      logic       exp_take;
      do_reset;
      exp_pc = 8'h00;
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 5; k++) begin
            r3 = r3_vals[k];
            jump_target = 8'(8'h20 + c * 8 + k);
            exp_take = cond_tab[c][4 - k];
            run_instr({5'b11000, 3'(c)});
            vectors++;
            if (exec_valid !== 1'b1 || branch_taken !== exp_take) begin
               miscompares++;
               $display("FAIL cond c=%0d r3=%h: got %b/%b want 1/%b", c, r3, exec_valid, branch_taken, exp_take);
            end
            tick;
            exp_pc = exp_take ? jump_target : exp_pc + 8'h01;
            vectors++;
            if (pc !== exp_pc) begin
               miscompares++; $display("FAIL cond_pc c=%0d r3=%h: got %h want %h", c, r3, pc, exp_pc);
            end
         end
      end
      r3 = 8'h01; jump_target = 8'hE0;
      run_instr(8'h07);
      vectors++;
      if (branch_taken !== 1'b0) begin miscompares++; $display("FAIL noncond: got %b want 0", branch_taken); end
      tick;
      vectors++;
      if (pc !== exp_pc + 8'h01) begin
         miscompares++; $display("FAIL noncond_pc: got %h want %h", pc, exp_pc + 8'h01);
      end
   endtask

   task test_stall;
      do_reset;
      r3 = 8'h00; jump_target = 8'h33;
      run_instr(8'hC5);
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 2) r3 = 8'h05;
         settle;
         vectors++;
         if (exec_valid !== 1'b0 || branch_taken !== 1'b0 || pc !== 8'h00) begin
            miscompares++;
            $display("FAIL stall k=%0d: got %b/%b/%h want 0/0/00", k, exec_valid, branch_taken, pc);
         end
         tick;
      end
      stall = 1'b0;
      settle;
      vectors++;
      if (exec_valid !== 1'b1 || branch_taken !== 1'b1) begin
         miscompares++; $display("FAIL stall_release: got %b/%b want 1/1", exec_valid, branch_taken);
      end
      tick;
      vectors++;
      if (exec_valid !== 1'b0 || pc !== 8'h33) begin
         miscompares++; $display("FAIL stall_after: got %b/%h want 0/33", exec_valid, pc);
      end
   endtask

   task test_reset_in_wait;
      do_reset;
      run_instr(8'h00);
      tick;
      wait_req;
      fetch_ack = 1'b1;
      tick;
      fetch_ack = 1'b0;
      rst_n = 1'b0;
      settle;
      vectors++;
      if (pc !== 8'h00 || fetch_req !== 1'b0) begin
         miscompares++; $display("FAIL rstwait_async: got %h/%b want 00/0", pc, fetch_req);
      end
      tick;
      rst_n = 1'b1; instr_valid = 1'b1; instr = 8'hC4;
      settle;
      vectors++;
      if (fetch_req !== 1'b0 || exec_valid !== 1'b0) begin
         miscompares++; $display("FAIL rstwait_w0: got %b/%b want 0/0", fetch_req, exec_valid);
      end
      tick;
      instr_valid = 1'b0;
      vectors++;
      if (fetch_req !== 1'b0 || exec_instr !== 8'h00) begin
         miscompares++; $display("FAIL rstwait_w1: got %b/%h want 0/00", fetch_req, exec_instr);
      end
      tick;
      vectors++;
      if (fetch_req !== 1'b1 || exec_valid !== 1'b0 || exec_instr !== 8'h00 || fetch_addr !== 8'h00) begin
         miscompares++;
         $display("FAIL rstwait_w2: got %b/%b/%h/%h want 1/0/00/00", fetch_req, exec_valid, exec_instr, fetch_addr);
      end
   endtask

   initial begin
      test_reset;
      test_streaming;
      test_wait_states;
      test_branch_eq;
      test_cond_table;
      test_stall;
      test_reset_in_wait;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
